// File: rtl/strobe_monitor.sv
// Receive side of the slow-strobe scheme: synchronises a slow toggling strobe,
// ticks on rising edges, measures the edge-to-edge period and tracks lock/loss.
module strobe_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int PERIOD_W    = 20,
   parameter int TIMEOUT     = 500_000,
   parameter int TOL         = 4,
   parameter int LOCK_COUNT  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                strobe_in,
   output logic                tick,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                locked,
   output logic                lost
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
   localparam logic [PERIOD_W-1:0] TOL_C     = PERIOD_W'(TOL);
   localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
   localparam logic [MW-1:0]       LOCK_C    = MW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TRACK   = 2'd2,
      LOST    = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_out;
   logic                   rise;

   state_t                 state, state_n;
   logic [PERIOD_W-1:0]    cnt, cnt_n;
   logic [PERIOD_W-1:0]    prev_period, prev_period_n;
   logic [PERIOD_W-1:0]    period_n;
   logic [PERIOD_W-1:0]    diff;
   logic [MW-1:0]          match_cnt, match_n, match_inc;
   logic                   tick_n, period_valid_n, locked_n, lost_n;

   // Metastability chain followed by the edge register holding the previous sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         match_cnt    <= '0;
         prev_period  <= '0;
         period       <= '0;
         tick         <= 1'b0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         lost         <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         match_cnt    <= match_n;
         prev_period  <= prev_period_n;
         period       <= period_n;
         tick         <= tick_n;
         period_valid <= period_valid_n;
         locked       <= locked_n;
         lost         <= lost_n;
      end
   end

   assign diff      = (cnt >= prev_period) ? (cnt - prev_period) : (prev_period - cnt);
   assign match_inc = (match_cnt == LOCK_C) ? match_cnt : match_cnt + MW'(1);

   // A rise always takes priority over the timeout, so a period of exactly
   // TIMEOUT cycles is still measured rather than reported as lost.
   always_comb begin
      state_n        = state;
      cnt_n          = rise ? PERIOD_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + PERIOD_W'(1));
      match_n        = match_cnt;
      prev_period_n  = prev_period;
      period_n       = period;
      tick_n         = rise;
      period_valid_n = 1'b0;
      locked_n       = locked;
      lost_n         = lost;

      unique case (state)
         IDLE: begin
            if (rise) begin
               state_n = MEASURE;
            end else if (cnt == TIMEOUT_C) begin
               state_n  = LOST;
               lost_n   = 1'b1;
               locked_n = 1'b0;
               match_n  = '0;
            end
         end
         MEASURE: begin
            if (rise) begin
               state_n        = TRACK;
               period_n       = cnt;
               period_valid_n = 1'b1;
               prev_period_n  = cnt;
               match_n        = '0;
            end else if (cnt == TIMEOUT_C) begin
               state_n  = LOST;
               lost_n   = 1'b1;
               locked_n = 1'b0;
               match_n  = '0;
            end
         end
         TRACK: begin
            if (rise) begin
               period_n       = cnt;
               period_valid_n = 1'b1;
               prev_period_n  = cnt;
               if (diff <= TOL_C) begin
                  match_n  = match_inc;
                  locked_n = (match_inc == LOCK_C);
               end else begin
                  match_n  = '0;
                  locked_n = 1'b0;
               end
            end else if (cnt == TIMEOUT_C) begin
               state_n  = LOST;
               lost_n   = 1'b1;
               locked_n = 1'b0;
               match_n  = '0;
            end
         end
         LOST: begin
            lost_n   = 1'b1;
            locked_n = 1'b0;
            match_n  = '0;
            if (rise) begin
               state_n = MEASURE;
               lost_n  = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
